// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM and its datapath muxes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_MEM  = 2'd1;
  localparam logic [1:0] M2R_PC4  = 2'd2;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_OR     = 3'd2;
  localparam logic [2:0] ALU_PASS_B = 3'd3;

  typedef enum logic [3:0] {
    CLS_NOP  = 4'd0,
    CLS_ADDU = 4'd1,
    CLS_SUBU = 4'd2,
    CLS_JR   = 4'd3,
    CLS_ORI  = 4'd4,
    CLS_LUI  = 4'd5,
    CLS_LW   = 4'd6,
    CLS_SW   = 4'd7,
    CLS_BEQ  = 4'd8,
    CLS_J    = 4'd9,
    CLS_JAL  = 4'd10
  } cls_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct classifier; anything outside the subset is flagged illegal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic       illegal
);

  // Map the instruction to its class; unknown encodings report NOP plus illegal
  always_comb begin
    cls     = CLS_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls     = CLS_ADDU;
          FN_SUBU: cls     = CLS_SUBU;
          FN_JR:   cls     = CLS_JR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls     = CLS_ORI;
      OP_LUI:  cls     = CLS_LUI;
      OP_LW:   cls     = CLS_LW;
      OP_SW:   cls     = CLS_SW;
      OP_BEQ:  cls     = CLS_BEQ;
      OP_J:    cls     = CLS_J;
      OP_JAL:  cls     = CLS_JAL;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared datapath.
// Optional performance counters (cyc_cnt, instr_cnt) are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic [1:0] mem_to_reg,
  output logic       alu_src,
  output logic [1:0] reg_dst,
  output logic [1:0] pc_src,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic       bus_err
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam int unsigned WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WAIT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  if (CNT_W == 0) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  state_e            state, state_n;
  cls_e              cls_q, cls_n, dec_cls;
  logic              dec_illegal;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic              expire;

  mc_ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // Last permitted wait cycle without an ack; an ack in this cycle still wins
  assign expire = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(WAIT_LAST));

  // State, latched instruction class and memory wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_FETCH;
      cls_q    <= CLS_NOP;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      cls_q    <= cls_n;
      wait_cnt <= wait_n;
    end
  end

  // Next state and control outputs; outputs are forced low while reset is asserted
  always_comb begin
    state_n    = state;
    cls_n      = cls_q;
    wait_n     = '0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = M2R_ALU;
    alu_src    = 1'b0;
    reg_dst    = RD_RT;
    pc_src     = PC_SEQ;
    ext_op     = EXT_ZERO;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    if (reset_n) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SEQ;
            state_n  = ST_DECODE;
          end else if (expire) begin
            bus_err = 1'b1;
          end else begin
            wait_n = wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          cls_n = dec_cls;
          if (dec_illegal) begin
            illegal = 1'b1;
            state_n = ST_FETCH;
          end else begin
            case (dec_cls)
              CLS_J: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                state_n  = ST_FETCH;
              end
              CLS_JAL: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                state_n  = ST_WB;
              end
              CLS_JR: begin
                pc_write = 1'b1;
                pc_src   = PC_REG;
                state_n  = ST_FETCH;
              end
              default: state_n = ST_EXEC;
            endcase
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_BEQ: begin
              pc_write = zero;
              pc_src   = PC_BRANCH;
              state_n  = ST_FETCH;
            end
            CLS_LW, CLS_SW: state_n = ST_MEM;
            default:        state_n = ST_WB;
          endcase
        end
        ST_MEM: begin
          dmem_req  = 1'b1;
          mem_write = (cls_q == CLS_SW);
          if (dmem_ack) begin
            state_n = (cls_q == CLS_SW) ? ST_FETCH : ST_WB;
          end else if (expire) begin
            bus_err = 1'b1;
            state_n = ST_FETCH;
          end else begin
            wait_n = wait_cnt + WAIT_W'(1);
          end
        end
        ST_WB: begin
          reg_write = 1'b1;
          case (cls_q)
            CLS_ADDU, CLS_SUBU: begin
              reg_dst    = RD_RD;
              mem_to_reg = M2R_ALU;
            end
            CLS_LW: begin
              reg_dst    = RD_RT;
              mem_to_reg = M2R_MEM;
            end
            CLS_JAL: begin
              reg_dst    = RD_RA;
              mem_to_reg = M2R_PC4;
            end
            default: begin
              reg_dst    = RD_RT;
              mem_to_reg = M2R_ALU;
            end
          endcase
          state_n = ST_FETCH;
        end
        default: state_n = ST_FETCH;
      endcase

      // ALU selects follow the latched class from EXEC through WB so datapath sources stay put
      if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
        case (cls_q)
          CLS_ADDU: alu_op = ALU_ADD;
          CLS_SUBU, CLS_BEQ: alu_op = ALU_SUB;
          CLS_ORI: begin
            alu_src = 1'b1;
            ext_op  = EXT_ZERO;
            alu_op  = ALU_OR;
          end
          CLS_LUI: begin
            alu_src = 1'b1;
            ext_op  = EXT_UPPER;
            alu_op  = ALU_PASS_B;
          end
          CLS_LW, CLS_SW: begin
            alu_src = 1'b1;
            ext_op  = EXT_SIGN;
            alu_op  = ALU_ADD;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic instr_done;

  // A return to FETCH from a later state retires an instruction unless it was an abort
  assign instr_done = reset_n && (state != ST_FETCH) && (state_n == ST_FETCH) && !illegal && !bus_err;

  // Free-running cycle counter and retired-instruction counter, both wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction expected cycle schedules built from the ISA rules.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;

  localparam int TO    = 16;
  localparam int NEVER = 1000;
  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
  localparam int K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [1:0] pc_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       illegal;
    logic       bus_err;
  } outs_t;

  typedef struct {
    logic  ia;
    logic  da;
    outs_t exp;
  } step_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, ir_write, pc_write, reg_write, mem_write;
  logic [1:0] mem_to_reg, reg_dst, pc_src, ext_op;
  logic       alu_src, illegal, bus_err;
  logic [2:0] alu_op;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
  logic [31:0] cyc_model;
  logic [31:0] instr_model = '0;
`endif

  int    errors = 0;
  int    checks = 0;
  step_t sched[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .pc_src     (pc_src),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .bus_err    (bus_err)
`ifdef MC_CTRL_PERF_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

`ifdef MC_CTRL_PERF_EN
  // Reference cycle count: clock edges seen since reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_model <= '0;
    else          cyc_model <= cyc_model + 32'd1;
  end
`endif

  function automatic outs_t outs_now();
    outs_t o;
    o.imem_req = imem_req;   o.dmem_req = dmem_req;   o.ir_write = ir_write;
    o.pc_write = pc_write;   o.reg_write = reg_write; o.mem_write = mem_write;
    o.mem_to_reg = mem_to_reg; o.alu_src = alu_src;   o.reg_dst = reg_dst;
    o.pc_src = pc_src;       o.ext_op = ext_op;       o.alu_op = alu_op;
    o.illegal = illegal;     o.bus_err = bus_err;
    return o;
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU : (fn == 6'h08) ? K_JR : K_ILL;
      6'h0D:   return K_ORI;
      6'h0F:   return K_LUI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // Operand selects an instruction needs while its ALU result is in use
  function automatic outs_t sel(input int k);
    outs_t o;
    o = '0;
    case (k)
      K_SUBU, K_BEQ: o.alu_op = 3'd1;
      K_ORI: begin o.alu_src = 1'b1; o.ext_op = 2'd0; o.alu_op = 3'd2; end
      K_LUI: begin o.alu_src = 1'b1; o.ext_op = 2'd2; o.alu_op = 3'd3; end
      K_LW, K_SW: begin o.alu_src = 1'b1; o.ext_op = 2'd1; o.alu_op = 3'd0; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic ia, input logic da, input outs_t o);
    step_t s;
    s.ia = ia; s.da = da; s.exp = o;
    sched.push_back(s);
  endtask

  // Expected per-cycle outputs for one instruction; id/dd are ack delays (>= TO means time out)
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int id, input int dd, output bit retires);
    int    k;
    outs_t o;
    k = kind_of(op, fn);
    sched.delete();
    retires = 1'b0;
    for (int c = 0; c < TO; c++) begin
      o = '0; o.imem_req = 1'b1;
      if (c == id) begin o.ir_write = 1'b1; o.pc_write = 1'b1; add(1'b1, noise(), o); break; end
      if (c == TO - 1) begin o.bus_err = 1'b1; add(1'b0, noise(), o); return; end
      add(1'b0, noise(), o);
    end
    o = '0;
    case (k)
      K_ILL: begin o.illegal = 1'b1; add(noise(), noise(), o); return; end
      K_J:   begin o.pc_write = 1'b1; o.pc_src = 2'd2; add(noise(), noise(), o); retires = 1'b1; return; end
      K_JR:  begin o.pc_write = 1'b1; o.pc_src = 2'd3; add(noise(), noise(), o); retires = 1'b1; return; end
      K_JAL: begin o.pc_write = 1'b1; o.pc_src = 2'd2; add(noise(), noise(), o); end
      default: add(noise(), noise(), o);
    endcase
    if (k != K_JAL) begin
      o = sel(k);
      if (k == K_BEQ) begin
        o.pc_write = z; o.pc_src = 2'd1;
        add(noise(), noise(), o);
        retires = 1'b1;
        return;
      end
      add(noise(), noise(), o);
      if (k == K_LW || k == K_SW) begin
        for (int c = 0; c < TO; c++) begin
          o = sel(k); o.dmem_req = 1'b1; o.mem_write = (k == K_SW);
          if (c == dd) begin add(noise(), 1'b1, o); break; end
          if (c == TO - 1) begin o.bus_err = 1'b1; add(noise(), 1'b0, o); return; end
          add(noise(), 1'b0, o);
        end
        if (k == K_SW) begin retires = 1'b1; return; end
      end
    end
    o = sel(k); o.reg_write = 1'b1;
    case (k)
      K_ADDU, K_SUBU: o.reg_dst = 2'd1;
      K_LW:           o.mem_to_reg = 2'd1;
      K_JAL:          begin o.reg_dst = 2'd2; o.mem_to_reg = 2'd2; end
      default: ;
    endcase
    add(noise(), noise(), o);
    retires = 1'b1;
  endtask

  // Drive one instruction cycle by cycle (inputs after negedge) and compare outputs
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int id, input int dd, input int max_steps);
    bit    ret;
    outs_t act;
    build(op, fn, z, id, dd, ret);
    foreach (sched[i]) begin
      if (i >= max_steps) break;
      @(negedge clk);
      opcode = op; funct = fn; zero = z;
      imem_ack = sched[i].ia; dmem_ack = sched[i].da;
      #1;
`ifdef MC_CTRL_PERF_EN
      if (i == 0) begin
        checks++;
        if (instr_cnt !== instr_model) begin
          errors++;
          $display("FAIL %s instr_cnt: got %0d expected %0d", name, instr_cnt, instr_model);
        end
        checks++;
        if (cyc_cnt !== cyc_model) begin
          errors++;
          $display("FAIL %s cyc_cnt: got %0d expected %0d", name, cyc_cnt, cyc_model);
        end
      end
`endif
      act = outs_now();
      checks++;
      if (act !== sched[i].exp) begin
        errors++;
        $display("FAIL %s step %0d: outputs=%h expected=%h", name, i, act, sched[i].exp);
      end
    end
`ifdef MC_CTRL_PERF_EN
    if (ret && max_steps >= sched.size()) instr_model = instr_model + 32'd1;
`endif
  endtask

  task automatic check_quiet(input string name);
    outs_t act;
    act = outs_now();
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h expected=%h", name, act, outs_t'('0));
    end
`ifdef MC_CTRL_PERF_EN
    checks++;
    if (cyc_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL %s counters: cyc=%0d instr=%0d expected 0 0", name, cyc_cnt, instr_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk); #1;
    check_quiet("reset_idle");
    imem_ack = 1'b1; dmem_ack = 1'b1;
    @(negedge clk); #1;
    check_quiet("reset_with_acks");
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
`ifdef MC_CTRL_PERF_EN
    instr_model = '0;
`endif
  endtask

  task automatic test_addu();
    run("addu", 6'h00, 6'h21, 1'b0, 0, 0, NEVER);
    run("subu", 6'h00, 6'h23, 1'b1, 1, 0, NEVER);
  endtask

  task automatic test_lw_delay();
    run("lw_wait3", 6'h23, 6'h15, 1'b0, 0, 3, NEVER);
  endtask

  task automatic test_beq();
    run("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0, NEVER);
    run("beq_not_taken", 6'h04, 6'h00, 1'b0, 0, 0, NEVER);
  endtask

  task automatic test_jumps();
    run("jal", 6'h03, 6'h11, 1'b0, 0, 0, NEVER);
    run("j", 6'h02, 6'h00, 1'b0, 0, 0, NEVER);
    run("jr", 6'h00, 6'h08, 1'b0, 2, 0, NEVER);
    run("ori", 6'h0D, 6'h3F, 1'b0, 0, 0, NEVER);
    run("lui", 6'h0F, 6'h00, 1'b0, 0, 0, NEVER);
  endtask

  task automatic test_timeouts();
    run("sw_timeout", 6'h2B, 6'h00, 1'b0, 0, NEVER, NEVER);
    run("sw_ack_at_expiry", 6'h2B, 6'h00, 1'b0, 0, TO - 1, NEVER);
    run("fetch_ack_at_expiry", 6'h00, 6'h21, 1'b0, TO - 1, 0, NEVER);
    run("fetch_timeout", 6'h00, 6'h21, 1'b0, NEVER, 0, NEVER);
    run("after_timeout", 6'h0D, 6'h00, 1'b0, 0, 0, NEVER);
  endtask

  task automatic test_illegal();
    run("illegal_op3f", 6'h3F, 6'h00, 1'b0, 0, 0, NEVER);
    run("illegal_funct20", 6'h00, 6'h20, 1'b0, 0, 0, NEVER);
  endtask

  task automatic test_reset_mid();
    run("lw_before_reset", 6'h23, 6'h00, 1'b0, 0, 8, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check_quiet("reset_mid_mem");
    imem_ack = 1'b1; dmem_ack = 1'b1;
    @(negedge clk); #1;
    check_quiet("reset_mid_held");
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
`ifdef MC_CTRL_PERF_EN
    instr_model = '0;
`endif
    run("lw_after_reset", 6'h23, 6'h00, 1'b0, 0, 0, NEVER);
  endtask

  task automatic test_random();
    logic [5:0] ops [13] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F, 6'h00, 6'h23};
    logic [5:0] fns [13] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h00};
    int d [2];
    int sel_i;
    for (int n = 0; n < 40; n++) begin
      sel_i = $urandom_range(0, 12);
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 9))
          6:       d[j] = TO - 1;
          7:       d[j] = TO;
          8:       d[j] = NEVER;
          9:       d[j] = $urandom_range(0, TO - 1);
          default: d[j] = $urandom_range(0, 3);
        endcase
      end
      run("random", ops[sel_i], fns[sel_i], 1'($urandom_range(0, 1)), d[0], d[1], NEVER);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_delay();
    test_beq();
    test_jumps();
    test_timeouts();
    test_illegal();
    test_reset_mid();
    test_random();
    run("tail_addu", 6'h00, 6'h21, 1'b0, 0, 0, NEVER);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control FSM for the MIPS-subset CPU.
- Sequences fetch, decode, execute, memory and writeback over one shared datapath.
- Drives the writeback select (mem_to_reg), ALU operand-B select (alu_src), register/PC/IR write strobes and request/ack handshakes to instruction and data memory.
- Sits beside the datapath; decodes opcode/funct from the IR.

Parameters:
- TIMEOUT, 16, cycles to wait for a memory ack before aborting; 0 disables the timeout.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- imem_ack  in  1  instruction memory done; IR data valid this cycle.
- dmem_ack  in  1  data memory done; read data valid / write committed.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- reg_write  out  1  register file write.
- mem_write  out  1  data write (qualifies dmem_req).
- mem_to_reg  out  2  writeback source: 0 ALU, 1 memory, 2 PC+4.
- alu_src  out  1  ALU B source: 0 RD2, 1 extended immediate.
- reg_dst  out  2  write register: 0 rt, 1 rd, 2 $31.
- pc_src  out  2  next PC: 0 PC+4, 1 branch target, 2 jump target, 3 rs.
- ext_op  out  2  0 zero-extend, 1 sign-extend, 2 shift to upper half.
- alu_op  out  3  0 ADD, 1 SUB, 2 OR, 3 PASS_B.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- bus_err  out  1  one-cycle pulse on a memory timeout.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB.
- Reset (async, immediate): state=FETCH, wait counter=0, instruction-class register=NOP. All strobes, req, illegal and bus_err = 0. All selects = 0.
- Reset mid-operation aborts with no write strobe glitch.
- FETCH: imem_req=1. When imem_ack=1, in the same cycle: ir_write=1, pc_write=1, pc_src=0. Next state DECODE.
- DECODE: latch class from opcode/funct. Classes: ADDU, SUBU, JR (op 0, funct 21h/23h/08h), ORI 0Dh, LUI 0Fh, LW 23h, SW 2Bh, BEQ 04h, J 02h, JAL 03h.
  - J: pc_write=1, pc_src=2 -> FETCH.
  - JAL: pc_write=1, pc_src=2 -> WB.
  - JR: pc_write=1, pc_src=3 -> FETCH.
  - Illegal: illegal=1 -> FETCH, no writes.
  - Otherwise -> EXEC.
- EXEC:
  - R-type: alu_src=0, alu_op from funct.
  - ORI: alu_src=1, ext_op=0, OR.
  - LUI: alu_src=1, ext_op=2, PASS_B.
  - LW/SW: alu_src=1, ext_op=1, ADD.
  - BEQ: alu_src=0, SUB; pc_write=zero, pc_src=1; -> FETCH.
  - Others: LW/SW -> MEM, rest -> WB.
- MEM: dmem_req=1 held until ack; mem_write=1 for SW. On dmem_ack: SW -> FETCH, LW -> WB.
- WB: reg_write=1 for exactly one cycle.
  - ADDU/SUBU: reg_dst=1, mem_to_reg=0.
  - ORI/LUI: reg_dst=0, mem_to_reg=0.
  - LW: reg_dst=0, mem_to_reg=1.
  - JAL: reg_dst=2, mem_to_reg=2.
  - Then -> FETCH.
- Zero-wait latencies in cycles: R/ORI/LUI 4, LW 5, SW 4, BEQ 3, J/JR 2, JAL 3.
- Select outputs are held at their EXEC values through MEM and WB for the same instruction, so datapath sources stay stable.
- Timeout:
  - Counter increments each cycle a req is high without ack; clears on ack or on state change.
  - When count reaches TIMEOUT-1 with no ack (TIMEOUT>0): bus_err=1, req drops, -> FETCH, PC not advanced, no register/memory write.
  - An ack in the same cycle as expiry wins; no error is raised.
- An ack in a state that is not waiting for it is ignored.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Defined: ports cyc_cnt and instr_cnt (out, CNT_W) are added.
  - cyc_cnt increments every cycle after reset.
  - instr_cnt increments on each transition into FETCH from a completed instruction, excluding illegal and bus_err aborts.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: these ports and their logic do not exist. Behaviour is otherwise identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encoding;
  - opcode/funct constants;
  - mem_to_reg, reg_dst, pc_src, ext_op, alu_op encodings (shared with the datapath muxes);
  - instruction-class enum.
- Sub-module mc_ctrl_decode: purely combinational opcode/funct -> class plus illegal flag. The FSM registers its output in DECODE.

Test Plan:
- ADDU, acks immediate -> FETCH, DECODE, EXEC, WB. reg_write=1 only in cycle 4 with reg_dst=1, mem_to_reg=0, alu_src=0. pc_write only in cycle 1.
- LW, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, mem_write=0. WB has mem_to_reg=1, reg_dst=0. Total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0 -> EXEC pc_write=1 with pc_src=1 in the first case, pc_write=0 in the second. 3 cycles each, no reg_write.
- JAL -> DECODE pc_write with pc_src=2. WB reg_write with reg_dst=2, mem_to_reg=2.
- SW with dmem_ack never asserted, TIMEOUT=16 -> bus_err pulse after 16 req cycles, return to FETCH, no reg_write, instr_cnt unchanged.
- Opcode 3Fh -> illegal pulse in DECODE, back to FETCH. Separately, reset_n low during an LW in MEM -> all outputs 0 immediately, FETCH after release.
